// File: rtl/fetch_prefetch_if.sv
// Instruction-fetch memory port between fetch_prefetch and main_memory.
// The fetch side owns addr/req; memory answers with instr and a one-cycle ack.
interface fetch_prefetch_if;
  logic [31:0] main_memory_instr_addr;
  logic [31:0] main_memory_instr;
  logic        main_memory_instr_req;
  logic        main_memory_instr_ack;

  modport master (
    output main_memory_instr_addr,
    output main_memory_instr_req,
    input  main_memory_instr,
    input  main_memory_instr_ack
  );

  modport slave (
    input  main_memory_instr_addr,
    input  main_memory_instr_req,
    output main_memory_instr,
    output main_memory_instr_ack
  );
endinterface

// File: rtl/fetch_prefetch.sv
// RV32I fetch stage with a BUF_DEPTH-entry prefetch buffer of {pc, instr} pairs.
// Sequential word fetches run ahead of decode; redirects/flush empty the buffer.
// A request killed while awaiting ack is tracked as stale and its data dropped.
// Optional feature macro FETCH_MISALIGN_EN: adds fetch_misaligned and blocks
// fetching after a misaligned redirect target; without it targets are word-aligned.
module fetch_prefetch #(
  parameter logic [31:0] PC_RESET  = 32'h0,
  parameter int          BUF_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  fetch_prefetch_if.master        mem,
  output logic [31:0]             fetch_instr,
  output logic [31:0]             pc,
  output logic                    fetch_valid,
  input  logic                    writeback_change_pc,
  input  logic [31:0]             writeback_next_pc,
  input  logic                    execute_change_pc,
  input  logic [31:0]             execute_next_pc,
  input  logic                    stall,
  input  logic                    flush,
`ifdef FETCH_MISALIGN_EN
  output logic                    fetch_misaligned,
`endif
  output logic                    next_clk_en
);

  localparam int               PTR_W      = $clog2(BUF_DEPTH);
  localparam int               CNT_W      = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(BUF_DEPTH);
  localparam logic [31:0]      NOP        = 32'h0000_0013;

  // F_STALE means a request is still outstanding but its data must be dropped.
  typedef enum logic [1:0] {F_IDLE, F_WAIT, F_STALE} fetch_state_t;

  fetch_state_t      state, state_n;
  logic [31:0]       fetch_pc, fetch_pc_n;
  logic [31:0]       addr_q, addr_n;
  logic [31:0]       last_pc;
  logic [31:0]       pc_buf    [BUF_DEPTH];
  logic [31:0]       instr_buf [BUF_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              redirect, kill, push, pop, issue_block;
  logic [31:0]       redirect_target, kill_target;

  // Writeback beats execute; target alignment depends on the misalign feature.
  always_comb begin
    redirect_target = writeback_change_pc ? writeback_next_pc : execute_next_pc;
`ifdef FETCH_MISALIGN_EN
    redirect_target = redirect_target;
`else
    redirect_target[1:0] = 2'b00;
`endif
  end

  assign redirect    = writeback_change_pc | execute_change_pc;
  assign kill        = redirect | flush;
  assign fetch_valid = (count != '0);
  assign fetch_instr = fetch_valid ? instr_buf[rd_ptr] : NOP;
  assign pc          = fetch_valid ? pc_buf[rd_ptr] : last_pc;
  assign kill_target = redirect ? redirect_target : (fetch_valid ? pc_buf[rd_ptr] : fetch_pc);
  assign next_clk_en = fetch_valid & ~stall & ~kill;
  assign pop         = next_clk_en;
  assign push        = (state == F_WAIT) && mem.main_memory_instr_ack && !kill;

  assign mem.main_memory_instr_req  = (state != F_IDLE);
  assign mem.main_memory_instr_addr = addr_q;

`ifdef FETCH_MISALIGN_EN
  logic misaligned_q, misaligned_n;

  // A redirect re-evaluates the flag; flush alone leaves it untouched.
  always_comb begin
    misaligned_n = misaligned_q;
    if (redirect) misaligned_n = |redirect_target[1:0];
  end

  // Misaligned flag register.
  always_ff @(posedge clk) begin
    if (!rst) misaligned_q <= 1'b0;
    else      misaligned_q <= misaligned_n;
  end

  assign issue_block      = misaligned_n;
  assign fetch_misaligned = misaligned_q;
`else
  assign issue_block = 1'b0;
`endif

  // Request FSM: issue, wait for ack, or drain a killed request.
  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    addr_n     = addr_q;
    case (state)
      F_IDLE: begin
        if (kill) fetch_pc_n = kill_target;
        if (!issue_block && (kill || count < FULL_COUNT)) begin
          state_n = F_WAIT;
          addr_n  = kill ? kill_target : fetch_pc;
        end
      end
      F_WAIT: begin
        if (mem.main_memory_instr_ack) begin
          state_n    = F_IDLE;
          fetch_pc_n = kill ? kill_target : fetch_pc + 32'd4;
        end else if (kill) begin
          state_n    = F_STALE;
          fetch_pc_n = kill_target;
        end
      end
      F_STALE: begin
        if (kill) fetch_pc_n = kill_target;
        if (mem.main_memory_instr_ack) state_n = F_IDLE;
      end
      default: state_n = F_IDLE;
    endcase
  end

  // FSM, fetch pc and request address registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= F_IDLE;
      fetch_pc <= PC_RESET;
      addr_q   <= PC_RESET;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      addr_q   <= addr_n;
    end
  end

  // Buffer pointers and occupancy; any kill empties the buffer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      last_pc <= PC_RESET;
    end else if (kill) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        last_pc <= pc_buf[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Buffer storage; the entry pc is the address the data was fetched from.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_buf[wr_ptr]    <= addr_q;
      instr_buf[wr_ptr] <= mem.main_memory_instr;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed self-checking bench for fetch_prefetch.
// Memory returns word (addr >> 2) one cycle after it sees a request.
module tb_fetch_prefetch;
  localparam int BUF_DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] fetch_instr, pc;
  logic        fetch_valid, next_clk_en;
  logic        writeback_change_pc, execute_change_pc, stall, flush;
  logic [31:0] writeback_next_pc, execute_next_pc;
`ifdef FETCH_MISALIGN_EN
  logic        fetch_misaligned;
`endif

  int checks   = 0;
  int failures = 0;

  fetch_prefetch_if mem_if ();

  fetch_prefetch #(.PC_RESET(32'h0), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .mem                 (mem_if),
    .fetch_instr         (fetch_instr),
    .pc                  (pc),
    .fetch_valid         (fetch_valid),
    .writeback_change_pc (writeback_change_pc),
    .writeback_next_pc   (writeback_next_pc),
    .execute_change_pc   (execute_change_pc),
    .execute_next_pc     (execute_next_pc),
    .stall               (stall),
    .flush               (flush),
`ifdef FETCH_MISALIGN_EN
    .fetch_misaligned    (fetch_misaligned),
`endif
    .next_clk_en         (next_clk_en)
  );

  always #5 clk = ~clk;

  // Memory responder; mem_hold withholds the ack.
  logic mem_hold = 1'b0;
  always @(posedge clk) begin
    if (!rst) begin
      mem_if.main_memory_instr_ack <= 1'b0;
      mem_if.main_memory_instr     <= 32'h0;
    end else if (mem_if.main_memory_instr_req && !mem_if.main_memory_instr_ack && !mem_hold) begin
      mem_if.main_memory_instr_ack <= 1'b1;
      mem_if.main_memory_instr     <= mem_if.main_memory_instr_addr >> 2;
    end else begin
      mem_if.main_memory_instr_ack <= 1'b0;
    end
  end

  // Observer: request rising edges, acks and pops per cycle.
  int          cyc = 0, acks = 0, pops = 0, rise_count = 0, ack_cyc = 0, rise_cyc = 0;
  logic        req_prev = 1'b0;
  logic [31:0] rise_addr = 32'h0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      req_prev <= 1'b0;
    end else begin
      if (mem_if.main_memory_instr_req && !req_prev) begin
        rise_count <= rise_count + 1;
        rise_addr  <= mem_if.main_memory_instr_addr;
        rise_cyc   <= cyc;
      end
      req_prev <= mem_if.main_memory_instr_req;
      if (mem_if.main_memory_instr_ack) begin
        acks    <= acks + 1;
        ack_cyc <= cyc;
      end
      if (next_clk_en) pops <= pops + 1;
    end
  end

  task automatic applyStimulus(input logic wb_c, input logic [31:0] wb_t,
                               input logic ex_c, input logic [31:0] ex_t,
                               input logic st, input logic fl);
    writeback_change_pc = wb_c;
    writeback_next_pc   = wb_t;
    execute_change_pc   = ex_c;
    execute_next_pc     = ex_t;
    stall               = st;
    flush               = fl;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic waitValid(input string tag);
    int n = 0;
    while (!fetch_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_valid"}, {31'b0, fetch_valid}, 32'd1);
  endtask

  task automatic waitRise(input int base, input string tag);
    int n = 0;
    while (rise_count <= base && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_rise"}, 32'(rise_count > base), 32'd1);
  endtask

  // Waits for a valid head, checks it, then steps past the pop edge.
  task automatic checkPop(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_instr);
    waitValid(tag);
    checkOutput({tag, "_pc"}, pc, exp_pc);
    checkOutput({tag, "_instr"}, fetch_instr, exp_instr);
    @(negedge clk);
  endtask

  // Holds a redirect for one cycle; returns at the negedge of the following cycle.
  task automatic doRedirect(input logic wb_c, input logic [31:0] wb_t,
                            input logic ex_c, input logic [31:0] ex_t, input logic st);
    applyStimulus(wb_c, wb_t, ex_c, ex_t, st, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, st, 1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    int hi;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_valid", {31'b0, fetch_valid}, 32'd0);
    checkOutput("rst_instr", fetch_instr, NOP);
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_req", {31'b0, mem_if.main_memory_instr_req}, 32'd0);
    checkOutput("rst_addr", mem_if.main_memory_instr_addr, 32'h0);
    checkOutput("rst_clken", {31'b0, next_clk_en}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 10; i++)
      checkPop($sformatf("run%0d", i), 32'(4 * i), 32'(i));

    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    repeat (24) @(negedge clk);
    checkOutput("stall_fill", 32'(acks - pops), 32'(BUF_DEPTH));
    hi = 0;
    repeat (8) begin
      @(negedge clk);
      if (mem_if.main_memory_instr_req) hi++;
    end
    checkOutput("stall_req_low", 32'(hi), 32'd0);
    checkOutput("stall_head_pc", pc, 32'h28);
    checkOutput("stall_head_instr", fetch_instr, 32'd10);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      checkPop($sformatf("resume%0d", i), 32'(32'h28 + 4 * i), 32'(10 + i));

    doRedirect(1'b0, 32'h0, 1'b1, 32'h10, 1'b0);
    checkOutput("ex_valid_drop", {31'b0, fetch_valid}, 32'd0);
    base = rise_count;
    waitRise(base, "ex");
    checkOutput("ex_req_addr", rise_addr, 32'h10);
    checkPop("ex_first", 32'h10, 32'd4);

    doRedirect(1'b1, 32'h18, 1'b1, 32'h40, 1'b0);
    checkOutput("prio_valid_drop", {31'b0, fetch_valid}, 32'd0);
    base = rise_count;
    waitRise(base, "prio");
    checkOutput("prio_req_addr", rise_addr, 32'h18);
    checkPop("prio_first", 32'h18, 32'd6);

    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    repeat (30) @(negedge clk);
    mem_hold = 1'b1;
    doRedirect(1'b0, 32'h0, 1'b1, 32'h08, 1'b1);
    base = rise_count;
    waitRise(base, "hold");
    checkOutput("hold_req_addr", rise_addr, 32'h08);
    repeat (2) @(negedge clk);
    doRedirect(1'b0, 32'h0, 1'b1, 32'h30, 1'b1);
    checkOutput("kill_req_held", {31'b0, mem_if.main_memory_instr_req}, 32'd1);
    checkOutput("kill_addr_stable", mem_if.main_memory_instr_addr, 32'h08);
    base = rise_count;
    repeat (3) @(negedge clk);
    mem_hold = 1'b0;
    waitRise(base, "kill");
    checkOutput("kill_req_addr", rise_addr, 32'h30);
    checkOutput("kill_after_ack", 32'(rise_cyc > ack_cyc), 32'd1);
    checkOutput("kill_no_data", {31'b0, fetch_valid}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkPop("kill_first", 32'h30, 32'd12);

    doRedirect(1'b0, 32'h0, 1'b1, 32'h0C, 1'b1);
    waitValid("flush_head");
    checkOutput("flush_head_pc", pc, 32'h0C);
    repeat (20) @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    #1;
    checkOutput("flush_no_pop", {31'b0, next_clk_en}, 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("flush_empty", {31'b0, fetch_valid}, 32'd0);
    checkPop("flush_replay0", 32'h0C, 32'd3);
    checkPop("flush_replay1", 32'h10, 32'd4);

    doRedirect(1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8, 1'b0);
    checkPop("wrap0", 32'hFFFF_FFF8, 32'h3FFF_FFFE);
    checkPop("wrap1", 32'hFFFF_FFFC, 32'h3FFF_FFFF);
    checkPop("wrap2", 32'h0000_0000, 32'h0000_0000);

`ifdef FETCH_MISALIGN_EN
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    repeat (30) @(negedge clk);
    checkOutput("mis_clear0", {31'b0, fetch_misaligned}, 32'd0);
    doRedirect(1'b0, 32'h0, 1'b1, 32'h22, 1'b1);
    checkOutput("mis_set", {31'b0, fetch_misaligned}, 32'd1);
    base = rise_count;
    repeat (10) @(negedge clk);
    checkOutput("mis_no_rise", 32'(rise_count - base), 32'd0);
    checkOutput("mis_req_low", {31'b0, mem_if.main_memory_instr_req}, 32'd0);
    checkOutput("mis_empty", {31'b0, fetch_valid}, 32'd0);
    doRedirect(1'b0, 32'h0, 1'b1, 32'h40, 1'b0);
    checkOutput("mis_cleared", {31'b0, fetch_misaligned}, 32'd0);
    checkPop("mis_resume", 32'h40, 32'd16);
`else
    doRedirect(1'b0, 32'h0, 1'b1, 32'h22, 1'b0);
    base = rise_count;
    waitRise(base, "align");
    checkOutput("align_req_addr", rise_addr, 32'h20);
    checkPop("align_first", 32'h20, 32'd8);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
